fd_inst_buffer: RTL and testbench
=================================

// Module: fd_inst_buffer
// PURPOSE
//   Fetch-to-decode boundary buffer. Holds up to DEPTH fetched (pc, inst) pairs.
//   Presents the head entry to the decode stage with opcode and funct3 pre-split,
//   so immediate-select and control decode run off registered fields.
//   Decouples instruction-memory latency from decode stalls.
//   Drops all held entries on a redirect from branch/jump resolution.
// PARAMETERS
//   XLEN   32  width of pc and instruction words
//   DEPTH  2   number of entries; power of two, >= 2
// PORTS
//   clk        in   1     clock; all state updates on rising edge
//   rst        in   1     asynchronous, active-high reset
//   f_valid    in   1     fetch offers an instruction this cycle
//   f_ready    out  1     buffer accepts; equals (count != DEPTH)
//   f_pc       in   XLEN  pc of offered instruction
//   f_inst     in   XLEN  offered instruction word
//   redirect   in   1     flush: discard all entries and any same-cycle push
//   d_valid    out  1     head entry valid (count != 0)
//   d_ready    in   1     decode consumes head this cycle
//   d_pc       out  XLEN  head pc
//   d_inst     out  XLEN  head instruction; NOP 32'h0000_0013 when empty
//   d_opcode   out  7     d_inst[6:0]
//   d_funct3   out  3     d_inst[14:12]
//   count      out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//   Clock and reset
//   - One clock. Reset is asynchronous and active-high.
//   - Reset values: count=0, rd_ptr=wr_ptr=0, d_valid=0, f_ready=1, d_pc=0,
//     d_inst=NOP, d_opcode=7'h13, d_funct3=0.
//   Handshakes
//   - push = f_valid & f_ready & ~redirect.
//   - pop = d_valid & d_ready & ~redirect.
//   - f_ready and d_valid are decoded from registered count only. They have no
//     combinational path from f_valid or d_ready.
//   Datapath
//   - Write: mem[wr_ptr] <= {f_pc, f_inst} on push.
//   - Pointers wrap modulo DEPTH.
//   - Latency: an entry pushed in cycle N is visible on d_* in cycle N+1 at the
//     earliest.
//   - d_* reflect mem[rd_ptr] when count != 0.
//   - When count == 0, d_inst is forced to NOP and d_pc holds the last value.
//   Occupancy and boundaries
//   - count' = count + push - pop.
//   - Push and pop in the same cycle: count unchanged, both pointers advance.
//   - Full (count == DEPTH): f_ready=0, so no push. A pop in that cycle frees a
//     slot visible next cycle; there is no same-cycle pass-through.
//   - Empty: d_valid=0, and d_ready is ignored.
//   Redirect
//   - redirect=1: next cycle count=0, rd_ptr=wr_ptr=0.
//   - The same-cycle f_valid and d_ready are ignored. Redirect wins over push
//     and pop.
//   - Redirect held for several cycles: the buffer stays empty and f_ready
//     stays 1.
//   - Reset asserted mid-operation: the async clear takes effect immediately;
//     outputs go to reset values without waiting for a clock edge.
//   - No X on d_opcode/d_funct3 while d_valid=0; NOP fields are driven.
// STRUCTURE
//   Shared package / defines include (opcodes file):
//   - OPC_* opcode constants (OPC_BRANCH, OPC_JAL, ...).
//   - INST_NOP = 32'h0000_0013.
//   - Field slice macros OPCODE_RANGE [6:0] and FUNCT3_RANGE [14:12].
//   Sub-module and implementation notes:
//   - One natural sub-module, fd_buf_ram: DEPTH x 2*XLEN register array,
//     1 write port, 1 async read port, no reset on storage.
//   - Pointer/count control stays in this module.
//   - No FSM beyond the count register.
// TESTING
//   T1 reset: assert rst mid-stream with count=2
//      -> immediately d_valid=0, f_ready=1, count=0, d_inst=0000_0013.
//   T2 fill: push pc 0x0/0x4 (inst 0x00500093, 0x00A00113), d_ready=0
//      -> count=2, f_ready=0.
//      d_pc=0x0, d_opcode=7'h13, d_funct3=0.
//   T3 drain order: from T2, d_ready=1 for 2 cycles
//      -> d_pc 0x0 then 0x4, then d_valid=0, count=0.
//   T4 simultaneous: count=1; push pc 0x8 and pop in the same cycle
//      -> count stays 1, head becomes pc 0x8.
//      Repeat 8 times to exercise pointer wrap.
//   T5 redirect: count=2, redirect=1 with f_valid=1, d_ready=1
//      -> next cycle count=0, offered inst not stored.
//      Push pc 0x100 next cycle -> it is the head.
//   T6 branch fields: push inst 0x00208463 (beq)
//      -> d_opcode=7'h63, d_funct3=3'b000.
//      Push 0x00109093 (slli) -> d_funct3=3'b001.

Source files
------------

// File: rtl/fd_inst_buffer_pkg.sv
// Shared RV32 opcode constants and field helpers for the fetch/decode boundary.
// Provides OPC_* opcodes, the canonical NOP, and opcode/funct3 slice helpers.
package fd_inst_buffer_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6f;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    // addi x0, x0, 0
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    localparam int OPCODE_MSB = 6;
    localparam int OPCODE_LSB = 0;
    localparam int FUNCT3_MSB = 14;
    localparam int FUNCT3_LSB = 12;

    function automatic logic [6:0] opcode_of(input logic [31:0] inst);
        return inst[OPCODE_MSB:OPCODE_LSB];
    endfunction

    function automatic logic [2:0] funct3_of(input logic [31:0] inst);
        return inst[FUNCT3_MSB:FUNCT3_LSB];
    endfunction

endpackage

// File: rtl/fd_buf_ram.sv
// Entry storage for the fetch/decode buffer: DEPTH x W register array.
// Ports: clk, we/waddr/wdata write port, raddr/rdata asynchronous read port.
module fd_buf_ram #(
    parameter int W     = 64,
    parameter int DEPTH = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];

    // Storage is intentionally not reset; readers qualify with occupancy.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fd_inst_buffer.sv
// Fetch-to-decode buffer holding up to DEPTH (pc, inst) pairs, head pre-split.
// Ports: clk, rst, f_valid/f_ready/f_pc/f_inst, redirect, d_valid/d_ready/d_*, count.
module fd_inst_buffer
    import fd_inst_buffer_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     f_valid,
    output logic                     f_ready,
    input  logic [XLEN-1:0]          f_pc,
    input  logic [XLEN-1:0]          f_inst,
    input  logic                     redirect,
    output logic                     d_valid,
    input  logic                     d_ready,
    output logic [XLEN-1:0]          d_pc,
    output logic [XLEN-1:0]          d_inst,
    output logic [6:0]               d_opcode,
    output logic [2:0]               d_funct3,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [XLEN-1:0]   last_pc_q;
    logic [2*XLEN-1:0] rdata;
    logic              push, pop;

    // Handshake flags come from registered count only.
    assign f_ready = (count_q != CW'(DEPTH));
    assign d_valid = (count_q != '0);
    assign count   = count_q;

    assign push = f_valid & f_ready & ~redirect;
    assign pop  = d_valid & d_ready & ~redirect;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            last_pc_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            // d_pc keeps showing the last head once the buffer drains.
            last_pc_q <= d_pc;
        end
    end

    fd_buf_ram #(
        .W     (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata ({f_pc, f_inst}),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    assign d_pc     = d_valid ? rdata[2*XLEN-1:XLEN] : last_pc_q;
    assign d_inst   = d_valid ? rdata[XLEN-1:0] : XLEN'(INST_NOP);
    assign d_opcode = opcode_of(d_inst[31:0]);
    assign d_funct3 = funct3_of(d_inst[31:0]);

endmodule

// File: tb/tb_fd_inst_buffer.sv
// Scoreboard bench for fd_inst_buffer: queue reference model plus monitor.
// Directed reset/fill/drain/wrap/redirect/field cases, then random traffic.
module tb_fd_inst_buffer;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              rst;
    logic              f_valid;
    logic              f_ready;
    logic [XLEN-1:0]   f_pc;
    logic [XLEN-1:0]   f_inst;
    logic              redirect;
    logic              d_valid;
    logic              d_ready;
    logic [XLEN-1:0]   d_pc;
    logic [XLEN-1:0]   d_inst;
    logic [6:0]        d_opcode;
    logic [2:0]        d_funct3;
    logic [$clog2(DEPTH):0] count;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO of {pc, inst} plus the last pc shown on d_pc.
    logic [63:0] exp_q [$];
    logic [31:0] last_pc = '0;
    bit          mon_en = 1'b0;

    always #5 clk = ~clk;

    fd_inst_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .f_valid  (f_valid),
        .f_ready  (f_ready),
        .f_pc     (f_pc),
        .f_inst   (f_inst),
        .redirect (redirect),
        .d_valid  (d_valid),
        .d_ready  (d_ready),
        .d_pc     (d_pc),
        .d_inst   (d_inst),
        .d_opcode (d_opcode),
        .d_funct3 (d_funct3),
        .count    (count)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive at negedge, then apply the spec rules at posedge.
    task automatic cycle(input bit fv, input logic [31:0] pc,
                         input logic [31:0] inst, input bit dr, input bit rd);
        int sz;
        @(negedge clk);
        f_valid  = fv;
        f_pc     = pc;
        f_inst   = inst;
        d_ready  = dr;
        redirect = rd;
        @(posedge clk);
        sz = exp_q.size();
        if (rd) begin
            exp_q.delete();
        end else begin
            if (dr && sz != 0) void'(exp_q.pop_front());
            if (fv && sz != DEPTH) exp_q.push_back({pc, inst});
        end
    endtask

    // Monitor: mid low phase, compare everything the DUT presents.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_en && !rst) begin
                chk("count", 64'(count), 64'(exp_q.size()));
                chk("d_valid", 64'(d_valid), 64'(exp_q.size() != 0));
                chk("f_ready", 64'(f_ready), 64'(exp_q.size() != DEPTH));
                if (exp_q.size() != 0) begin
                    chk("d_pc", 64'(d_pc), 64'(exp_q[0][63:32]));
                    chk("d_inst", 64'(d_inst), 64'(exp_q[0][31:0]));
                    chk("d_opcode", 64'(d_opcode), 64'(exp_q[0][6:0]));
                    chk("d_funct3", 64'(d_funct3), 64'(exp_q[0][14:12]));
                    last_pc = exp_q[0][63:32];
                end else begin
                    chk("empty_pc", 64'(d_pc), 64'(last_pc));
                    chk("empty_inst", 64'(d_inst), 64'(NOP));
                    chk("empty_opc", 64'(d_opcode), 64'h13);
                    chk("empty_f3", 64'(d_funct3), 64'h0);
                end
            end
        end
    end

    initial begin
        logic [31:0] pc;
        rst = 1'b1;
        f_valid = 0; f_pc = '0; f_inst = '0; d_ready = 0; redirect = 0;
        #12;
        chk("rst_count", 64'(count), 64'h0);
        chk("rst_dvalid", 64'(d_valid), 64'h0);
        chk("rst_fready", 64'(f_ready), 64'h1);
        chk("rst_pc", 64'(d_pc), 64'h0);
        chk("rst_inst", 64'(d_inst), 64'(NOP));
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        // T2 fill
        cycle(1, 32'h0, 32'h0050_0093, 0, 0);
        cycle(1, 32'h4, 32'h00A0_0113, 0, 0);
        cycle(1, 32'h8, 32'hDEAD_BEEF, 0, 0);
        #2;
        chk("t2_count", 64'(count), 64'h2);
        chk("t2_fready", 64'(f_ready), 64'h0);
        chk("t2_pc", 64'(d_pc), 64'h0);
        chk("t2_opc", 64'(d_opcode), 64'h13);
        chk("t2_f3", 64'(d_funct3), 64'h0);

        // T3 drain
        cycle(0, 0, 0, 1, 0);
        #2 chk("t3_pc1", 64'(d_pc), 64'h4);
        cycle(0, 0, 0, 1, 0);
        #2;
        chk("t3_valid", 64'(d_valid), 64'h0);
        chk("t3_count", 64'(count), 64'h0);
        chk("t3_hold_pc", 64'(d_pc), 64'h4);
        cycle(0, 0, 0, 1, 0);

        // T4 simultaneous push/pop with pointer wrap
        cycle(1, 32'h4, 32'h0000_0013, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cycle(1, 32'h8 + 32'(i) * 4, 32'h0010_0093 + 32'(i), 1, 0);
            #2;
            chk("t4_count", 64'(count), 64'h1);
            chk("t4_pc", 64'(d_pc), 64'(32'h8 + 32'(i) * 4));
        end

        // T5 redirect wins over push and pop
        cycle(1, 32'h40, 32'h0000_0033, 0, 0);
        cycle(1, 32'h44, 32'hAAAA_AAAA, 1, 1);
        #2 chk("t5_count", 64'(count), 64'h0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        #2 chk("t5_fready", 64'(f_ready), 64'h1);
        cycle(1, 32'h100, 32'h0000_0073, 0, 0);
        #2 chk("t5_head", 64'(d_pc), 64'h100);
        cycle(0, 0, 0, 1, 0);

        // T6 branch / shift fields
        cycle(1, 32'h200, 32'h0020_8463, 0, 0);
        #2;
        chk("t6_beq_opc", 64'(d_opcode), 64'h63);
        chk("t6_beq_f3", 64'(d_funct3), 64'h0);
        cycle(1, 32'h204, 32'h0010_9093, 1, 0);
        #2 chk("t6_slli_f3", 64'(d_funct3), 64'h1);
        cycle(0, 0, 0, 1, 0);

        // Random traffic
        pc = 32'h1000;
        for (int i = 0; i < 400; i++) begin
            bit fv, dr, rd;
            fv = ($urandom_range(9) < 7);
            dr = ($urandom_range(9) < 5);
            rd = ($urandom_range(19) == 0);
            cycle(fv, pc, $urandom, dr, rd);
            pc += 4;
        end

        // T1 reset mid-stream with a full buffer
        cycle(1, 32'h300, 32'h0000_0013, 0, 0);
        cycle(1, 32'h304, 32'h0000_0013, 0, 0);
        cycle(0, 0, 0, 0, 0);
        #2 chk("t1_full", 64'(count), 64'h2);
        mon_en = 1'b0;
        @(negedge clk);
        f_valid = 0; d_ready = 0; redirect = 0;
        #2 rst = 1'b1;
        #1;
        chk("t1_count", 64'(count), 64'h0);
        chk("t1_dvalid", 64'(d_valid), 64'h0);
        chk("t1_fready", 64'(f_ready), 64'h1);
        chk("t1_inst", 64'(d_inst), 64'(NOP));
        chk("t1_pc", 64'(d_pc), 64'h0);
        exp_q.delete();
        last_pc = '0;
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        cycle(1, 32'h400, 32'h0000_0063, 0, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0);
        @(negedge clk);
        #2;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
